uart: RTL and testbench
=======================

Name: uart

Overview:
- 8N1 UART peripheral at the far end of the GPIO pin mux.
- Drives uart_tx into the GPIO output routing and consumes uart_rx from the GPIO input select.
- Sits on the same 5-bit register bus as the GPIO block and raises a level interrupt.
- Provides a programmable 16x-oversampling baud divisor, a single-entry TX holding register and a 4-deep RX FIFO.

Parameters:
- RX_DEPTH, 4, RX FIFO entries (power of 2, at least 2).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- uart_rx  input  1  serial input from the GPIO mux; asynchronous to clk.
- uart_tx  output  1  serial output to the GPIO mux; idles high.
- interrupt  output  1  level interrupt, combinational from flags and enables.
- reg_addr  input  5  register address.
- reg_data_in  input  8  write data.
- reg_data_out  output  8  combinational read data.
- reg_write  input  1  one-cycle write strobe.
- reg_read  input  1  one-cycle read strobe; has a side effect only at address 0.

Behaviour:
- Registers. Any address not listed reads 0 and ignores writes.
  - 0 DATA: a write loads the TX hold register. The write is ignored if the hold register is already full. A read returns the RX FIFO head (0 if empty). reg_read at address 0 pops the FIFO if it is non-empty.
  - 1 STATUS: bit0 rx_avail (FIFO non-empty); bit1 rx_full; bit2 tx_busy (shifter active); bit3 tx_hold_full; bit4 rx_overrun (sticky); bit5 frame_err (sticky). Writing 1 to bit4 or bit5 clears that flag.
  - 2 IEN: bit0 rx_avail, bit1 tx_empty (not hold_full and not busy), bit2 error (overrun | frame_err).
  - 4 DIVL, 5 DIVH: 16-bit divisor DIV. One oversample tick occurs every DIV+1 clocks, so one bit period = 16*(DIV+1) clocks.
- interrupt = (ien0 & rx_avail) | (ien1 & tx_empty) | (ien2 & (rx_overrun | frame_err)).
- Reset values:
  - uart_tx=1, interrupt=0.
  - IEN=0, DIV=0, FIFO empty, all flags 0.
  - TX and RX state machines in IDLE; prescalers cleared.
  - Reset takes effect mid-frame with no completion of the byte in progress.
- TX FSM: states IDLE, START, DATA, STOP. It has its own prescaler and 4-bit tick counter, both restarted on every transition.
  - IDLE: if hold_full, move the hold register to the shifter, clear hold_full and enter START. uart_tx goes low the clock after the transfer. A write to an idle UART therefore drives uart_tx low 2 clocks after reg_write.
  - START: holds 0 for 16 ticks.
  - DATA: sends 8 bits LSB first, 16 ticks each.
  - STOP: holds 1 for 16 ticks.
  - At the end of STOP, if hold_full, go directly to START with no idle gap; otherwise go to IDLE.
  - A DATA write issued while the shifter is busy and the hold register is empty is accepted and queued back-to-back.
- RX path: uart_rx passes through a 2-flop synchroniser. RX FSM states are IDLE, START, DATA, STOP, with a separate prescaler.
  - IDLE: a synchronised 0 enters START with the tick count cleared.
  - START: at tick 8, if the line is 1, treat it as a false start and return to IDLE; otherwise restart counting.
  - DATA: samples at every 16th tick (bit centre), shifting LSB first, 8 bits.
  - STOP: sample at the bit centre.
    - If the sample is 0: set frame_err, discard the byte and return to IDLE only after the line is seen high.
    - If the sample is 1: push the byte. If the FIFO is full, drop the byte and set rx_overrun.
  - A push and a pop in the same cycle on a full FIFO succeed without overrun. On an empty FIFO, the pushed byte is not visible until the next cycle.
- DIV changes take effect at the next prescaler reload; frames already in flight are not re-timed.
- Flag set and software clear in the same cycle: set wins.

Test Plan:
- Reset with uart_tx observed low-impedance high: reset=0 at any time -> uart_tx=1, interrupt=0, STATUS reads 0x00, DIV reads 0.
- DIV=0, write 0xA5 to DATA -> uart_tx low from cycle +2 for 16 clocks, then 1,0,1,0,0,1,0,1 at 16 clocks each, then stop high for 16 clocks; STATUS bit2 clears after the stop bit.
- DIV=3, drive uart_rx with 0x3C framed at 64 clocks/bit -> after the stop-bit centre, STATUS=0x01 and DATA reads 0x3C. With IEN=0x01, interrupt=1 until a reg_read at address 0, after which STATUS=0x00.
- DIV=0, send 5 frames without reading -> STATUS=0x13 (rx_avail, rx_full, overrun). Four reads return frames 1-4 in order. Writing 0x10 to STATUS clears overrun.
- Stop bit forced to 0 on byte 0x55 -> frame_err=1, FIFO stays empty. A 4-clock low glitch on idle uart_rx is rejected as a false start and no flags change.
- Write 0x11 then 0x22 back-to-back -> the second write is accepted into the hold register. Frame 0x22's start bit immediately follows frame 0x11's stop bit. A third write while hold_full is ignored.

Source files
------------

// File: rtl/uart.sv
// 8N1 UART on the GPIO register bus: programmable 16x-oversampling divisor,
// single-entry TX holding register, RX FIFO and a level interrupt.
module uart #(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       interrupt,
  input  logic [4:0] reg_addr,
  input  logic [7:0] reg_data_in,
  output logic [7:0] reg_data_out,
  input  logic       reg_write,
  input  logic       reg_read
);
  localparam int unsigned PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic          wr_data, wr_stat, wr_ien, wr_divl, wr_divh, rd_data;
  logic [2:0]    ien_q;
  logic [7:0]    divl_q, divh_q;
  logic [DW-1:0] div;
  logic [7:0]    hold_q;
  logic          hold_full_q, ovr_q, ferr_q;

  state_e        tx_state_q, tx_state_d;
  logic [DW-1:0] tx_pre_q, tx_pre_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d, tx_tick, tx_end, tx_load, tx_busy;

  state_e        rx_state_q, rx_state_d;
  logic [DW-1:0] rx_pre_q, rx_pre_d;
  logic [3:0]    rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_s1_q, rx_s2_q, rx_brk_q, rx_brk_d, rx_tick, rx_push, ferr_set;

  logic [7:0]    mem_q [RX_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] fcnt_q;
  logic          rx_avail, rx_full, pop, push_ok, ovr_set;

  assign wr_data = reg_write && (reg_addr == 5'd0);
  assign wr_stat = reg_write && (reg_addr == 5'd1);
  assign wr_ien  = reg_write && (reg_addr == 5'd2);
  assign wr_divl = reg_write && (reg_addr == 5'd4);
  assign wr_divh = reg_write && (reg_addr == 5'd5);
  assign rd_data = reg_read  && (reg_addr == 5'd0);
  assign div     = {divh_q, divl_q};

  assign rx_avail = (fcnt_q != '0);
  assign rx_full  = (fcnt_q == CW'(RX_DEPTH));
  assign pop      = rd_data && rx_avail;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok  = rx_push && (!rx_full || pop);
  assign ovr_set  = rx_push && rx_full && !pop;

  assign tx_tick = (tx_pre_q == '0);
  assign tx_end  = tx_tick && (tx_cnt_q == 4'hf);
  assign tx_busy = (tx_state_q != S_IDLE);
  assign rx_tick = (rx_pre_q == '0);

  // TX next state: prescaler reloads with DIV so a new divisor applies at the next reload.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_pre_d   = tx_tick ? div : tx_pre_q - DW'(1);
    tx_cnt_d   = tx_tick ? tx_cnt_q + 4'd1 : tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_pre_d = div;
        tx_cnt_d = '0;
        if (hold_full_q) begin
          tx_load    = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: if (tx_end) begin
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_end) begin
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
      end
      S_STOP: if (tx_end) begin
        tx_load    = hold_full_q;
        tx_state_d = hold_full_q ? S_START : S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_load) tx_sh_d = hold_q;
    case (tx_state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // RX next state: start validated at mid-bit, then data/stop sampled every 16 ticks.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_pre_d   = rx_tick ? div : rx_pre_q - DW'(1);
    rx_cnt_d   = rx_tick ? rx_cnt_q + 4'd1 : rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_brk_d   = rx_brk_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_pre_d = div;
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_brk_d = 1'b0;
        if (!rx_s2_q) rx_state_d = S_START;
      end
      S_START: if (rx_tick && (rx_cnt_q == 4'd7)) begin
        rx_pre_d   = div;
        rx_cnt_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tick && (rx_cnt_q == 4'hf)) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end
      S_STOP: begin
        if (rx_brk_q) begin
          rx_pre_d = div;
          rx_cnt_d = '0;
          if (rx_s2_q) rx_state_d = S_IDLE;
        end else if (rx_tick && (rx_cnt_q == 4'hf)) begin
          if (rx_s2_q) begin
            rx_push    = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            rx_brk_d = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien_q       <= '0;
      divl_q      <= '0;
      divh_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      tx_state_q  <= S_IDLE;
      tx_pre_q    <= '0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      if (wr_ien)  ien_q  <= reg_data_in[2:0];
      if (wr_divl) divl_q <= reg_data_in;
      if (wr_divh) divh_q <= reg_data_in;
      if (tx_load) begin
        hold_full_q <= 1'b0;
      end else if (wr_data && !hold_full_q) begin
        hold_q      <= reg_data_in;
        hold_full_q <= 1'b1;
      end
      if (ovr_set)                         ovr_q  <= 1'b1;
      else if (wr_stat && reg_data_in[4])  ovr_q  <= 1'b0;
      if (ferr_set)                        ferr_q <= 1'b1;
      else if (wr_stat && reg_data_in[5])  ferr_q <= 1'b0;
      tx_state_q <= tx_state_d;
      tx_pre_q   <= tx_pre_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_pre_q   <= '0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_brk_q   <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      fcnt_q     <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_pre_q   <= rx_pre_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_brk_q   <= rx_brk_d;
      if (push_ok) wp_q <= wp_q + PW'(1);
      if (pop)     rp_q <= rp_q + PW'(1);
      fcnt_q <= fcnt_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= rx_sh_q;
  end

  always_comb begin
    reg_data_out = '0;
    case (reg_addr)
      5'd0: if (rx_avail) reg_data_out = mem_q[rp_q];
      5'd1: reg_data_out = {2'b00, ferr_q, ovr_q, hold_full_q, tx_busy, rx_full, rx_avail};
      5'd2: reg_data_out = {5'b00000, ien_q};
      5'd4: reg_data_out = divl_q;
      5'd5: reg_data_out = divh_q;
      default: reg_data_out = '0;
    endcase
  end

  assign uart_tx   = tx_q;
  assign interrupt = (ien_q[0] && rx_avail) ||
                     (ien_q[1] && !hold_full_q && !tx_busy) ||
                     (ien_q[2] && (ovr_q || ferr_q));

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: reset values, TX framing, RX FIFO/overrun, frame error,
// false start, back-to-back TX and mid-frame reset.
module tb_uart;
  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       uart_tx;
  logic       interrupt;
  logic [4:0] reg_addr;
  logic [7:0] reg_data_in;
  logic [7:0] reg_data_out;
  logic       reg_write;
  logic       reg_read;

  int total = 0;
  int bad   = 0;

  uart #(.RX_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .interrupt    (interrupt),
    .reg_addr     (reg_addr),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .reg_write    (reg_write),
    .reg_read     (reg_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    reg_addr = a; reg_data_in = d; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    reg_addr = a;
    #1 d = reg_data_out;
  endtask

  task automatic pop(output logic [7:0] d);
    reg_addr = 5'd0; reg_read = 1'b1;
    #1 d = reg_data_out;
    @(negedge clk);
    reg_read = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int bclk, input logic stopv);
    uart_rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (bclk) @(negedge clk);
    end
    uart_rx = stopv;
    repeat (bclk) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] b);
    chk({tag, "_start"}, 16'(uart_tx), 16'h0);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      chk({tag, "_bit"}, 16'(uart_tx), 16'(b[i]));
    end
    repeat (16) @(negedge clk);
    chk({tag, "_stop"}, 16'(uart_tx), 16'h1);
  endtask

  logic [7:0] d;
  logic [7:0] frames [5];

  initial begin
    frames[0] = 8'h11; frames[1] = 8'h22; frames[2] = 8'h33;
    frames[3] = 8'h44; frames[4] = 8'h55;
    reset = 1'b0; uart_rx = 1'b1; reg_addr = '0; reg_data_in = '0;
    reg_write = 1'b0; reg_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(uart_tx), 16'h1);
    chk("rst_irq", 16'(interrupt), 16'h0);
    reset = 1'b1;
    @(negedge clk);
    rd(5'd1, d); chk("rst_status", 16'(d), 16'h00);
    rd(5'd4, d); chk("rst_divl", 16'(d), 16'h00);
    rd(5'd5, d); chk("rst_divh", 16'(d), 16'h00);
    rd(5'd3, d); chk("unmapped", 16'(d), 16'h00);

    // TX 0xA5 at DIV=0
    wr(5'd0, 8'hA5);
    chk("tx_pre1", 16'(uart_tx), 16'h1);
    @(negedge clk);
    chk("tx_pre2", 16'(uart_tx), 16'h1);
    @(negedge clk);
    chk("tx_low_at2", 16'(uart_tx), 16'h0);
    repeat (8) @(negedge clk);
    chk_frame("a5", 8'hA5);
    rd(5'd1, d); chk("tx_busy_stop", 16'(d), 16'h04);
    @(negedge clk);
    repeat (8) @(negedge clk);
    rd(5'd1, d); chk("tx_done_status", 16'(d), 16'h00);
    chk("tx_idle_line", 16'(uart_tx), 16'h1);
    wr(5'd2, 8'h02);
    chk("irq_tx_empty", 16'(interrupt), 16'h1);
    wr(5'd2, 8'h00);

    // RX 0x3C at DIV=3
    wr(5'd4, 8'h03);
    send(8'h3C, 64, 1'b1);
    rd(5'd1, d); chk("rx_status", 16'(d), 16'h01);
    rd(5'd0, d); chk("rx_peek", 16'(d), 16'h3C);
    wr(5'd2, 8'h01);
    chk("rx_irq_on", 16'(interrupt), 16'h1);
    pop(d); chk("rx_pop", 16'(d), 16'h3C);
    rd(5'd1, d); chk("rx_status_empty", 16'(d), 16'h00);
    chk("rx_irq_off", 16'(interrupt), 16'h0);
    wr(5'd2, 8'h00);

    // Five frames into a 4-deep FIFO at DIV=0
    wr(5'd4, 8'h00);
    for (int k = 0; k < 5; k++) send(frames[k], 16, 1'b1);
    repeat (2) @(negedge clk);
    rd(5'd1, d); chk("ovr_status", 16'(d), 16'h13);
    for (int k = 0; k < 4; k++) begin
      pop(d); chk("ovr_pop", 16'(d), 16'(frames[k]));
    end
    rd(5'd1, d); chk("ovr_sticky", 16'(d), 16'h10);
    wr(5'd1, 8'h10);
    rd(5'd1, d); chk("ovr_clear", 16'(d), 16'h00);

    // Frame error, then false start, then recovery
    send(8'h55, 16, 1'b0);
    repeat (4) @(negedge clk);
    rd(5'd1, d); chk("ferr_status", 16'(d), 16'h20);
    wr(5'd2, 8'h04);
    chk("ferr_irq", 16'(interrupt), 16'h1);
    wr(5'd1, 8'h20);
    rd(5'd1, d); chk("ferr_clear", 16'(d), 16'h00);
    chk("ferr_irq_off", 16'(interrupt), 16'h0);
    wr(5'd2, 8'h00);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    rd(5'd1, d); chk("glitch_status", 16'(d), 16'h00);
    send(8'h5A, 16, 1'b1);
    repeat (2) @(negedge clk);
    rd(5'd1, d); chk("recover_status", 16'(d), 16'h01);
    pop(d); chk("recover_data", 16'(d), 16'h5A);

    // Back-to-back TX with a third write while the hold register is full
    wr(5'd0, 8'h11);
    @(negedge clk);
    rd(5'd1, d); chk("b2b_busy", 16'(d), 16'h04);
    wr(5'd0, 8'h22);
    rd(5'd1, d); chk("b2b_hold", 16'(d), 16'h0C);
    wr(5'd0, 8'h33);
    repeat (7) @(negedge clk);
    chk_frame("f11", 8'h11);
    repeat (16) @(negedge clk);
    chk_frame("f22", 8'h22);
    repeat (16) @(negedge clk);
    chk("b2b_no_third", 16'(uart_tx), 16'h1);
    rd(5'd1, d); chk("b2b_done", 16'(d), 16'h00);

    // Reset in the middle of a frame
    wr(5'd4, 8'h03);
    wr(5'd0, 8'h00);
    repeat (30) @(negedge clk);
    chk("mid_tx_low", 16'(uart_tx), 16'h0);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", 16'(uart_tx), 16'h1);
    chk("mid_rst_irq", 16'(interrupt), 16'h0);
    rd(5'd4, d); chk("mid_rst_div", 16'(d), 16'h00);
    rd(5'd1, d); chk("mid_rst_status", 16'(d), 16'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_no_resume", 16'(uart_tx), 16'h1);
    rd(5'd1, d); chk("mid_idle_status", 16'(d), 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
